latch_event_monitor: RTL
========================

Name: latch_event_monitor

Overview:
- Downstream consumer of the transparent latch output Q. The latch is level-sensitive and not clocked, so its output is asynchronous to the system clock.
- This block synchronises that output into the CLK domain and debounces it. It emits one-cycle edge pulses and counts rising events in a saturating counter.
- It reports each new count to a consumer through a VLD/ACK handshake.

Parameters:
- WIDTH, 8, width of event counter and CNT snapshot.
- STABLE, 4, consecutive cycles of differing synchronised level required before LVL changes; legal range 1..15.

Ports:
- CLK  input  1  system clock, rising edge.
- R  input  1  reset, synchronous, active-low.
- Q_IN  input  1  latch output Q, asynchronous to CLK.
- CLR  input  1  synchronous clear of event counter and OVF.
- ACK  input  1  consumer acknowledge of current report.
- LVL  output  1  debounced, synchronised level of Q_IN.
- RISE  output  1  one-cycle pulse on debounced 0->1.
- FALL  output  1  one-cycle pulse on debounced 1->0.
- CNT  output  WIDTH  count snapshot, valid while VLD=1.
- VLD  output  1  report valid.
- OVF  output  1  sticky saturation flag.

Behaviour:
- Reset (R=0 at a CLK edge): sync flops, stability counter, LVL, RISE, FALL, VLD, OVF, CNT, internal count and pending flag all go to 0; FSM goes to IDLE.
- Reset overrides every other input and may occur in any state. Any in-flight report is discarded.
- Synchroniser: two flops (s1, s2). The debounce logic uses only s2.
- Debounce:
  - Stability counter increments each edge while s2 != LVL.
  - It clears to 0 on any edge where s2 == LVL.
  - When it would reach STABLE, LVL <= s2 and the counter clears.
  - Latency from a stable Q_IN change (first sampling edge counted) to LVL change is 2+STABLE edges. With STABLE=4, that is 6.
  - Glitches shorter than STABLE cycles at s2 produce no LVL change.
- RISE/FALL: registered, high for exactly the one cycle in which LVL first shows its new value. They are mutually exclusive and never high in back-to-back cycles unless STABLE=1.
- Event counter: increments by 1 on each RISE. It saturates at 2^WIDTH-1, and the first increment attempted at saturation sets OVF.
- OVF is sticky until CLR or reset.
- CLR: count <= 0 and OVF <= 0. CLR beats a simultaneous RISE, so the count ends at 0. CLR does not affect VLD, CNT or the FSM.
- FSM states: IDLE, REPORT, GAP.
  - IDLE (VLD=0): on RISE, CNT <= saturated count+1 (same value the counter takes), then go to REPORT.
  - REPORT (VLD=1, CNT held stable):
    - A RISE sets pending and updates only the internal count.
    - On ACK with pending=1 (including a RISE in the same cycle), go to GAP and clear pending.
    - On ACK with pending=0, go to IDLE.
  - GAP (VLD=0 for exactly one cycle): CNT <= current count (includes any RISE this cycle), then go to REPORT.
  - ACK while VLD=0 is ignored.
- CNT keeps its last snapshot when VLD=0.

Test Plan:
- Reset then Q_IN 0->1 held, STABLE=4 -> LVL=1 and RISE pulse 6 edges after the change; VLD=1, CNT=1 the next cycle; ACK -> VLD=0 the following cycle, FSM in IDLE.
- 3-cycle high glitch on Q_IN, STABLE=4 -> LVL stays 0; no RISE, FALL or VLD.
- Three debounced rises with no ACK -> VLD stays high with CNT=1; ACK -> VLD=0 for one cycle, then VLD=1 with CNT=3.
- WIDTH=4, 17 rises with prompt ACKs -> final CNT=15, OVF=1; CLR -> OVF=0; next rise reports CNT=1.
- CLR asserted in the same cycle as RISE in IDLE -> internal count 0, snapshot CNT=1 still reported; the following rise reports CNT=1.
- R=0 while VLD=1 and Q_IN=1 -> all outputs 0 the next edge. After R=1 with Q_IN still 1 -> RISE after 6 edges and a report with CNT=1.

Source files
------------

// File: rtl/latch_event_monitor.sv
// Synchronises and debounces an asynchronous latch output, emits edge pulses,
// counts rising events with saturation and reports each new count over VLD/ACK.
module latch_event_monitor #(
  parameter int WIDTH  = 8,
  parameter int STABLE = 4
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             Q_IN,
  input  logic             CLR,
  input  logic             ACK,
  output logic             LVL,
  output logic             RISE,
  output logic             FALL,
  output logic [WIDTH-1:0] CNT,
  output logic             VLD,
  output logic             OVF
);

  localparam logic [3:0] STABLE_M1 = 4'(STABLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPORT = 2'd1,
    GAP    = 2'd2
  } state_t;

  logic [1:0]       sync_q;
  logic             s2;
  logic [3:0]       stab_q, stab_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] inc_val;
  logic             at_max;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] cnt_q;
  logic             vld_q;
  logic             pend_q;
  state_t           state_q;

  // Two-flop synchroniser; only the second stage feeds the debouncer.
  always_ff @(posedge CLK) begin
    if (!R) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], Q_IN};
    end
  end

  assign s2 = sync_q[1];

  always_comb begin
    stab_d = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2 != lvl_q) begin
      if (stab_q == STABLE_M1) begin
        lvl_d  = s2;
        rise_d = s2;
        fall_d = ~s2;
      end else begin
        stab_d = stab_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      stab_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      stab_q <= stab_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // The FSM snapshots the same saturated value the counter is about to take.
  assign at_max  = &count_q;
  assign inc_val = at_max ? count_q : count_q + WIDTH'(1);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (CLR) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rise_q) begin
      count_d = inc_val;
      if (at_max) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q <= IDLE;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (rise_q) begin
            cnt_q   <= inc_val;
            vld_q   <= 1'b1;
            state_q <= REPORT;
          end
        end
        REPORT: begin
          if (ACK) begin
            pend_q  <= 1'b0;
            vld_q   <= 1'b0;
            state_q <= (pend_q || rise_q) ? GAP : IDLE;
          end else if (rise_q) begin
            pend_q <= 1'b1;
          end
        end
        GAP: begin
          cnt_q   <= rise_q ? inc_val : count_q;
          vld_q   <= 1'b1;
          state_q <= REPORT;
        end
        default: begin
          vld_q   <= 1'b0;
          pend_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign LVL  = lvl_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign CNT  = cnt_q;
  assign VLD  = vld_q;
  assign OVF  = ovf_q;

endmodule
